// File: rtl/hqx_diff_seq.sv
// Pixel-similarity checker: centre vs eight neighbours in a luma/chroma difference space -> 8-bit differs pattern.
// Latency: m_valid rises 8/COMPS clocks after accept; one job per 8/COMPS+1 cycles with m_ready held high.
// Backpressure: holds DONE (s_ready low, m_pattern stable) until m_ready; a job offered in DONE is taken back-to-back.
//
// Ports: clk, reset (async, active-high); s_valid/s_ready/s_center/s_nbr job input (neighbour i at
// [i*3*CW +: 3*CW], order TL,T,TR,L,R,BL,B,BR); m_valid/m_ready/m_pattern result; busy = not idle.
// Optional macro HQX_DIFF_RUNTIME_TH_EN adds th_y/th_u/th_v inputs, latched per job, replacing Y_TH/U_TH/V_TH.
module hqx_diff_seq #(
    parameter int CW    = 6,
    parameter int DROP  = 1,
    parameter int COMPS = 2,
    parameter int Y_TH  = 24,
    parameter int U_TH  = 4,
    parameter int V_TH  = 6
) (
    input  logic              clk,
    input  logic              reset,
`ifdef HQX_DIFF_RUNTIME_TH_EN
    input  logic [7:0]        th_y,
    input  logic [7:0]        th_u,
    input  logic [7:0]        th_v,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3*CW-1:0]   s_center,
    input  logic [24*CW-1:0]  s_nbr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_pattern,
    output logic              busy
);

    localparam int PIX_W = 3 * CW;
    localparam int D     = CW - DROP + 1;
    localparam logic [2:0] LAST_STEP = 3'(8 / COMPS - 1);

    // Parameter legality is checked at elaboration.
    if (!(COMPS == 1 || COMPS == 2 || COMPS == 4 || COMPS == 8)) begin : g_bad_comps
        $error("hqx_diff_seq: COMPS must be 1, 2, 4 or 8");
    end
    if (DROP < 0 || DROP > CW - 2) begin : g_bad_drop
        $error("hqx_diff_seq: DROP must be in 0..CW-2");
    end
    if (Y_TH > (1 << (D + 1)) || U_TH > (1 << D) || V_TH > (1 << (D + 1))) begin : g_bad_th
        $error("hqx_diff_seq: threshold exceeds the range of its difference term");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state;
    logic [2:0]          step;
    logic [PIX_W-1:0]    center_q;
    logic [24*CW-1:0]    nbr_q;
    logic [PIX_W-1:0]    nbr_arr [8];
    logic [2:0]          base;
    logic [COMPS-1:0]    diff_now;
    logic                accept;
    int                  thy, thu, thv;

`ifdef HQX_DIFF_RUNTIME_TH_EN
    logic [7:0] th_y_q, th_u_q, th_v_q;
    assign thy = int'(th_y_q);
    assign thu = int'(th_u_q);
    assign thv = int'(th_v_q);
`else
    assign thy = Y_TH;
    assign thu = U_TH;
    assign thv = V_TH;
`endif

    // The derived terms never exceed D+2 signed bits, so plain int arithmetic
    // gives exactly the sign-extended, unsaturated results.
    function automatic logic px_differs(input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] n,
                                        input int yt, input int ut, input int vt);
        int dr, dg, db, t, y, u, v;
        dr = int'(c[CW-1:0] >> DROP)      - int'(n[CW-1:0] >> DROP);
        dg = int'(c[2*CW-1:CW] >> DROP)   - int'(n[2*CW-1:CW] >> DROP);
        db = int'(c[3*CW-1:2*CW] >> DROP) - int'(n[3*CW-1:2*CW] >> DROP);
        t  = dr + db;
        y  = t + dg;
        u  = dr - db;
        v  = 2 * dg - t;
        return !((y >= -yt) && (y < yt) && (u >= -ut) && (u < ut) && (v >= -vt) && (v < vt));
    endfunction

    assign busy    = (state != ST_IDLE);
    // Ready in DONE follows m_ready so a finished job can hand over to the next one in one edge.
    assign s_ready = !reset && ((state == ST_IDLE) || (state == ST_DONE && m_ready));
    assign accept  = s_valid && s_ready;

    always_comb begin
        base = 3'(int'(step) * COMPS);
        for (int i = 0; i < 8; i++) begin
            nbr_arr[i] = nbr_q[i*PIX_W +: PIX_W];
        end
        diff_now = '0;
        for (int k = 0; k < COMPS; k++) begin
            diff_now[k] = px_differs(center_q, nbr_arr[base + 3'(k)], thy, thu, thv);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            step      <= '0;
            m_pattern <= '0;
            m_valid   <= 1'b0;
            center_q  <= '0;
            nbr_q     <= '0;
`ifdef HQX_DIFF_RUNTIME_TH_EN
            th_y_q    <= 8'(Y_TH);
            th_u_q    <= 8'(U_TH);
            th_v_q    <= 8'(V_TH);
`endif
        end else begin
            if (accept) begin
                center_q  <= s_center;
                nbr_q     <= s_nbr;
`ifdef HQX_DIFF_RUNTIME_TH_EN
                th_y_q    <= th_y;
                th_u_q    <= th_u;
                th_v_q    <= th_v;
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_RUN;
                        step      <= '0;
                        m_pattern <= '0;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < COMPS; k++) begin
                        m_pattern[base + 3'(k)] <= diff_now[k];
                    end
                    if (step == LAST_STEP) begin
                        state   <= ST_DONE;
                        step    <= '0;
                        m_valid <= 1'b1;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (s_valid) begin
                            state     <= ST_RUN;
                            step      <= '0;
                            m_pattern <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hqx_diff_seq.sv
module tb_hqx_diff_seq;

    localparam int CW = 6;
    localparam int PW = 3 * CW;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid;
    logic [PW-1:0]    s_center;
    logic [8*PW-1:0]  s_nbr;
    logic             m_ready;

    logic             s_ready_w [4];
    logic             m_valid_w [4];
    logic [7:0]       m_pat_w   [4];
    logic             busy_w    [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0 is the default build (COMPS=2); 1..3 are COMPS 1, 4, 8.
    int exp_lat [4] = '{4, 8, 2, 1};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int C = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 8;
        hqx_diff_seq #(.COMPS(C)) u_dut (
            .clk       (clk),
            .reset     (reset),
`ifdef HQX_DIFF_RUNTIME_TH_EN
            .th_y      (8'd24),
            .th_u      (8'd4),
            .th_v      (8'd6),
`endif
            .s_valid   (s_valid),
            .s_ready   (s_ready_w[gi]),
            .s_center  (s_center),
            .s_nbr     (s_nbr),
            .m_valid   (m_valid_w[gi]),
            .m_ready   (m_ready),
            .m_pattern (m_pat_w[gi]),
            .busy      (busy_w[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int r, input int g, input int b);
        return {6'(b), 6'(g), 6'(r)};
    endfunction

    task automatic set_all_nbr(input logic [PW-1:0] p);
        for (int i = 0; i < 8; i++) s_nbr[i*PW +: PW] = p;
    endtask

    // Called #1 after a posedge; leaves the bench #1 after the accept edge.
    task automatic send();
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(input int inst, output int lat);
        lat = 0;
        while (!m_valid_w[inst] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic job_c_setup();
        s_center = pix(10, 20, 30);
        s_nbr[0*PW +: PW] = pix(10, 20, 30);
        s_nbr[1*PW +: PW] = pix(12, 20, 30);
        s_nbr[2*PW +: PW] = pix(10, 20, 40);
        s_nbr[3*PW +: PW] = pix(10, 30, 30);
        s_nbr[4*PW +: PW] = pix(10, 22, 30);
        s_nbr[5*PW +: PW] = pix(0, 0, 0);
        s_nbr[6*PW +: PW] = pix(14, 20, 32);
        s_nbr[7*PW +: PW] = pix(10, 20, 24);
    endtask

    task automatic job_b_setup();
        s_center = pix(0, 4, 0);
        set_all_nbr(pix(0, 4, 0));
        s_nbr[1*PW +: PW] = pix(0, 0, 0);
        s_nbr[2*PW +: PW] = pix(63, 63, 63);
        s_nbr[7*PW +: PW] = pix(1, 4, 0);
    endtask

    task automatic sweep(input string tag, input logic [7:0] exp_pat);
        int lat [4];
        logic [7:0] pat [4];
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0;
            pat[i] = 8'h00;
        end
        send();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (m_valid_w[i] && lat[i] == 0) begin
                    lat[i] = cyc;
                    pat[i] = m_pat_w[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(exp_lat[i]));
            check($sformatf("%s_pat%0d", tag, i), 32'(pat[i]), 32'(exp_pat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset    = 1'b1;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        s_center = '0;
        s_nbr    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready_w[0]), 32'd0);
        check("rst_m_valid", 32'(m_valid_w[0]), 32'd0);
        check("rst_pattern", 32'(m_pat_w[0]), 32'h00);
        check("rst_busy",    32'(busy_w[0]), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(s_ready_w[0]), 32'd1);

        // All-zero job.
        idle_cycle();
        send();
        check("zero_busy", 32'(busy_w[0]), 32'd1);
        wait_valid(0, lat);
        check("zero_lat", 32'(lat), 32'd4);
        check("zero_pat", 32'(m_pat_w[0]), 32'h00);
        idle_cycle();
        check("zero_idle", 32'(busy_w[0]), 32'd0);

        // Neighbour R differs in r only: u = -8.
        s_center = pix(0, 0, 0);
        set_all_nbr(pix(0, 0, 0));
        s_nbr[4*PW +: PW] = pix(16, 0, 0);
        send();
        wait_valid(0, lat);
        check("u_pat", 32'(m_pat_w[0]), 32'h10);
        idle_cycle();

        // Green difference of 3 after DROP: v = 6 is outside.
        s_center = pix(0, 6, 0);
        set_all_nbr(pix(0, 6, 0));
        s_nbr[0*PW +: PW] = pix(0, 0, 0);
        send();
        wait_valid(0, lat);
        check("v_pat", 32'(m_pat_w[0]), 32'h01);
        idle_cycle();

        // Green diff 2 inside, far neighbour 2 differs, LSB-only r diff ignored.
        job_b_setup();
        send();
        wait_valid(0, lat);
        check("b_pat", 32'(m_pat_w[0]), 32'h04);
        idle_cycle();

        // Stall in DONE with a new job offered, then back-to-back accept.
        job_c_setup();
        send();
        wait_valid(0, lat);
        check("c_lat", 32'(lat), 32'd4);
        check("c_pat", 32'(m_pat_w[0]), 32'h2C);
        m_ready = 1'b0;
        s_valid = 1'b1;
        set_all_nbr(pix(63, 63, 63));
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            check($sformatf("stall_pat%0d", i), 32'(m_pat_w[0]), 32'h2C);
            check($sformatf("stall_vld%0d", i), 32'(m_valid_w[0]), 32'd1);
            check($sformatf("stall_rdy%0d", i), 32'(s_ready_w[0]), 32'd0);
        end
        m_ready = 1'b1;
        #1;
        check("b2b_s_ready", 32'(s_ready_w[0]), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("b2b_m_valid", 32'(m_valid_w[0]), 32'd0);
        check("b2b_busy", 32'(busy_w[0]), 32'd1);
        wait_valid(0, lat);
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_pat", 32'(m_pat_w[0]), 32'hFF);

        // Drain every instance, then reset during the second RUN step.
        repeat (12) idle_cycle();
        job_c_setup();
        send();
        idle_cycle();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_m_valid", 32'(m_valid_w[0]), 32'd0);
        check("mid_rst_pattern", 32'(m_pat_w[0]), 32'h00);
        check("mid_rst_busy",    32'(busy_w[0]), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready_w[0]), 32'd0);
        idle_cycle();
        reset = 1'b0;
        idle_cycle();
        job_b_setup();
        send();
        wait_valid(0, lat);
        check("after_rst_lat", 32'(lat), 32'd4);
        check("after_rst_pat", 32'(m_pat_w[0]), 32'h04);

        // Same jobs across COMPS = 2, 1, 4, 8.
        repeat (12) idle_cycle();
        job_b_setup();
        sweep("sweep_b", 8'h04);
        repeat (4) idle_cycle();
        job_c_setup();
        sweep("sweep_c", 8'h2C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
